// File: rtl/decode_pkg.sv
// Shared widths, lane indices and ID-age comparison for the decode result arbiter.
package decode_pkg;

  localparam int unsigned NUM_LANES  = 8;
  localparam int unsigned LANE_DEPTH = 4;
  localparam int unsigned PAYLOAD_W  = 160;
  localparam int unsigned MAJ_W      = 64;
  localparam int unsigned MIN_W      = 7;

  typedef enum logic [2:0] {
    LANE_A  = 3'd0,
    LANE_B  = 3'd1,
    LANE_D  = 3'd2,
    LANE_DS = 3'd3,
    LANE_X  = 3'd4,
    LANE_XO = 3'd5,
    LANE_M  = 3'd6,
    LANE_XL = 3'd7
  } lane_e;

  // Strictly older: ties return 0 so the caller's scan order breaks them.
  function automatic logic is_older(input logic [MAJ_W-1:0] a_maj,
                                    input logic [MIN_W-1:0] a_min,
                                    input logic [MAJ_W-1:0] b_maj,
                                    input logic [MIN_W-1:0] b_min);
    return {a_maj, a_min} < {b_maj, b_min};
  endfunction

endpackage

// File: rtl/decode_lane_fifo.sv
// Per-lane circular buffer holding decoder results until the arbiter selects them.
module decode_lane_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [Width-1:0]         push_data,
  input  logic                     pop,
  output logic [Width-1:0]         head,
  output logic [$clog2(Depth):0]   count,
  output logic                     full
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  logic [Width-1:0] mem [Depth];
  logic [PtrW-1:0]  rd_ptr;
  logic [PtrW-1:0]  wr_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PtrW'(1);
      if (pop)  rd_ptr <= rd_ptr + PtrW'(1);
      case ({push, pop})
        2'b10:   count <= count + CntW'(1);
        2'b01:   count <= count - CntW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: stale entries are unreachable once count is cleared.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign head = mem[rd_ptr];
  assign full = (count == CntW'(Depth));

endmodule

// File: rtl/decode_result_arbiter.sv
// Merges per-format decoder lanes into one oldest-first registered output stream.
// Optional perf counters are enabled by defining DECODE_ARB_PERF_COUNTERS_EN.
module decode_result_arbiter
  import decode_pkg::*;
#(
  parameter int unsigned NumLanes                = NUM_LANES,
  parameter int unsigned LaneDepth               = LANE_DEPTH,
  parameter int unsigned PayloadWidth            = PAYLOAD_W,
  parameter int unsigned instructionCounterWidth = MAJ_W,
  parameter int unsigned instMinIdWidth          = MIN_W
) (
  input  logic                                          clock_i,
  input  logic                                          reset_i,
  input  logic [NumLanes-1:0]                           lane_valid_i,
  input  logic [NumLanes*PayloadWidth-1:0]              lane_payload_i,
  input  logic [NumLanes*instructionCounterWidth-1:0]   lane_majId_i,
  input  logic [NumLanes*instMinIdWidth-1:0]            lane_minId_i,
  output logic [NumLanes-1:0]                           lane_stall_o,
  output logic                                          out_valid_o,
  input  logic                                          out_ready_i,
  output logic [PayloadWidth-1:0]                       out_payload_o,
  output logic [instructionCounterWidth-1:0]            out_majId_o,
  output logic [instMinIdWidth-1:0]                     out_minId_o,
  output logic [$clog2(NumLanes)-1:0]                   out_lane_o
`ifdef DECODE_ARB_PERF_COUNTERS_EN
  ,
  output logic [31:0]                                   perf_emitted_o,
  output logic [31:0]                                   perf_stall_o
`endif
);

  localparam int unsigned LaneW  = $clog2(NumLanes);
  localparam int unsigned CntW   = $clog2(LaneDepth) + 1;
  localparam int unsigned EntryW = PayloadWidth + instructionCounterWidth + instMinIdWidth;

  logic [NumLanes-1:0]                push;
  logic [NumLanes-1:0]                pop;
  logic [NumLanes-1:0]                full;
  logic [CntW-1:0]                    count        [NumLanes];
  logic [EntryW-1:0]                  head         [NumLanes];
  logic [PayloadWidth-1:0]            head_payload [NumLanes];
  logic [instructionCounterWidth-1:0] head_maj     [NumLanes];
  logic [instMinIdWidth-1:0]          head_min     [NumLanes];

  for (genvar g = 0; g < NumLanes; g++) begin : g_lane
    assign push[g] = lane_valid_i[g] & ~full[g];

    decode_lane_fifo #(
      .Depth (LaneDepth),
      .Width (EntryW)
    ) u_fifo (
      .clk       (clock_i),
      .rst       (reset_i),
      .push      (push[g]),
      .push_data ({lane_payload_i[g*PayloadWidth +: PayloadWidth],
                   lane_majId_i[g*instructionCounterWidth +: instructionCounterWidth],
                   lane_minId_i[g*instMinIdWidth +: instMinIdWidth]}),
      .pop       (pop[g]),
      .head      (head[g]),
      .count     (count[g]),
      .full      (full[g])
    );

    assign {head_payload[g], head_maj[g], head_min[g]} = head[g];
  end

  // Stall comes straight from registered FIFO occupancy, never from out_ready_i.
  assign lane_stall_o = full;

  logic             any_head;
  logic [LaneW-1:0] sel;
  logic             load;

  // Ascending scan with a strict comparison lets the lowest lane win exact ties.
  always_comb begin
    any_head = 1'b0;
    sel      = '0;
    for (int unsigned i = 0; i < NumLanes; i++) begin
      if (count[i] != '0) begin
        if (!any_head || is_older(head_maj[i], head_min[i], head_maj[sel], head_min[sel])) begin
          sel      = LaneW'(i);
          any_head = 1'b1;
        end
      end
    end
  end

  assign load = any_head & (~out_valid_o | out_ready_i);

  always_comb begin
    pop = '0;
    for (int unsigned i = 0; i < NumLanes; i++) begin
      pop[i] = load && (sel == LaneW'(i));
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      out_valid_o   <= 1'b0;
      out_payload_o <= '0;
      out_majId_o   <= '0;
      out_minId_o   <= '0;
      out_lane_o    <= '0;
    end else if (load) begin
      out_valid_o   <= 1'b1;
      out_payload_o <= head_payload[sel];
      out_majId_o   <= head_maj[sel];
      out_minId_o   <= head_min[sel];
      out_lane_o    <= sel;
    end else if (out_ready_i) begin
      out_valid_o   <= 1'b0;
    end
  end

`ifdef DECODE_ARB_PERF_COUNTERS_EN
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      perf_emitted_o <= '0;
      perf_stall_o   <= '0;
    end else begin
      if (out_valid_o && out_ready_i) perf_emitted_o <= perf_emitted_o + 32'd1;
      if (|lane_stall_o)              perf_stall_o   <= perf_stall_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_decode_result_arbiter.sv
// Scoreboard bench for decode_result_arbiter: directed lane traffic, monitor-side checking.
module tb_decode_result_arbiter;
  import decode_pkg::*;

  localparam int unsigned NL = NUM_LANES;
  localparam int unsigned PW = PAYLOAD_W;
  localparam int unsigned MW = MAJ_W;
  localparam int unsigned NW = MIN_W;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NL-1:0]     lane_valid = '0;
  logic [NL*PW-1:0]  lane_payload = '0;
  logic [NL*MW-1:0]  lane_maj = '0;
  logic [NL*NW-1:0]  lane_min = '0;
  logic [NL-1:0]     lane_stall;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [PW-1:0]     out_payload;
  logic [MW-1:0]     out_maj;
  logic [NW-1:0]     out_min;
  logic [2:0]        out_lane;
`ifdef DECODE_ARB_PERF_COUNTERS_EN
  logic [31:0]       perf_emitted;
  logic [31:0]       perf_stall;
`endif

  decode_result_arbiter #(
    .NumLanes                (NL),
    .LaneDepth               (LANE_DEPTH),
    .PayloadWidth            (PW),
    .instructionCounterWidth (MW),
    .instMinIdWidth          (NW)
  ) dut (
    .clock_i        (clk),
    .reset_i        (rst),
    .lane_valid_i   (lane_valid),
    .lane_payload_i (lane_payload),
    .lane_majId_i   (lane_maj),
    .lane_minId_i   (lane_min),
    .lane_stall_o   (lane_stall),
    .out_valid_o    (out_valid),
    .out_ready_i    (out_ready),
    .out_payload_o  (out_payload),
    .out_majId_o    (out_maj),
    .out_minId_o    (out_min),
    .out_lane_o     (out_lane)
`ifdef DECODE_ARB_PERF_COUNTERS_EN
    ,
    .perf_emitted_o (perf_emitted),
    .perf_stall_o   (perf_stall)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [MW-1:0] maj;
    logic [NW-1:0] min;
    logic [2:0]    lane;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   stall_cycles = 0;
  bit   counting = 1'b0;

  function automatic logic [PW-1:0] payload_of(input logic [MW-1:0] maj, input logic [NW-1:0] min);
    return {32'hDEAD_BEEF ^ maj[31:0], 57'd0, min, maj};
  endfunction

  task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: every accepted output is popped and compared against the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (counting && (|lane_stall)) stall_cycles++;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out actual=maj %0d lane %0d required=none", out_maj, out_lane);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("out_maj", PW'(out_maj), PW'(e.maj));
          check("out_min", PW'(out_min), PW'(e.min));
          check("out_lane", PW'(out_lane), PW'(e.lane));
          check("out_payload", out_payload, payload_of(e.maj, e.min));
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic expect_out(input logic [MW-1:0] maj, input logic [NW-1:0] min, input int lane);
    exp_t e;
    e.maj  = maj;
    e.min  = min;
    e.lane = 3'(lane);
    sb.push_back(e);
  endtask

  task automatic set_lane(input int lane, input logic [MW-1:0] maj, input logic [NW-1:0] min);
    lane_valid[lane]            = 1'b1;
    lane_payload[lane*PW +: PW] = payload_of(maj, min);
    lane_maj[lane*MW +: MW]     = maj;
    lane_min[lane*NW +: NW]     = min;
  endtask

  task automatic idle();
    lane_valid = '0;
  endtask

  // Holds the lane valid until the edge that actually captures it.
  task automatic send(input int lane, input logic [MW-1:0] maj, input logic [NW-1:0] min);
    logic st;
    int   n;
    set_lane(lane, maj, min);
    n = 0;
    do begin
      st = lane_stall[lane];
      step();
      n++;
    end while (st && n < 200);
    if (st) begin
      checks++;
      errors++;
      $display("FAIL send_timeout actual=stalled required=captured lane %0d", lane);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || out_valid) && n < 100) begin
      step();
      n++;
    end
    check("drain_empty", PW'(sb.size()), '0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst = 1'b1;
    idle();
    sb.delete();
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    // Reset state
    #1;
    check("rst_valid", PW'(out_valid), '0);
    check("rst_stall", PW'(lane_stall), '0);
    check("rst_maj", PW'(out_maj), '0);
    check("rst_lane", PW'(out_lane), '0);
    step();
    step();
    rst = 1'b0;

    // Single instruction, two-edge latency
    out_ready = 1'b1;
    expect_out(5, 0, int'(LANE_A));
    set_lane(int'(LANE_A), 5, 0);
    step();
    idle();
    check("lat_not_yet", PW'(out_valid), '0);
    step();
    check("lat_valid", PW'(out_valid), PW'(1));
    check("lat_maj", PW'(out_maj), PW'(5));
    check("lat_lane", PW'(out_lane), '0);
    check("lat_stall", PW'(lane_stall), '0);
    drain();

    // Ordering across lanes
    expect_out(10, 0, 4); expect_out(11, 0, 0); expect_out(12, 0, 4); expect_out(13, 0, 0);
    send(int'(LANE_X), 10, 0); idle();
    send(int'(LANE_A), 11, 0); idle();
    send(int'(LANE_X), 12, 0); idle();
    send(int'(LANE_A), 13, 0); idle();
    drain();

    // Micro-op tie on majId, minId decides
    expect_out(7, 0, 2); expect_out(7, 1, 5);
    set_lane(int'(LANE_XO), 7, 1);
    set_lane(int'(LANE_D), 7, 0);
    step(); idle();
    drain();

    // Exact tie: lowest lane index wins
    expect_out(9, 4, 1); expect_out(9, 4, 3);
    set_lane(int'(LANE_DS), 9, 4);
    set_lane(int'(LANE_B), 9, 4);
    step(); idle();
    drain();

    // Concatenated compare: max minId of smaller majId is still older
    expect_out(50, 127, 6); expect_out(51, 0, 0);
    set_lane(int'(LANE_A), 51, 0);
    set_lane(int'(LANE_M), 50, 127);
    step(); idle();
    drain();

    // Out-of-arrival-order selection while slot is held
    out_ready = 1'b0;
    expect_out(30, 0, 0); expect_out(31, 0, 7); expect_out(32, 0, 6); expect_out(33, 0, 1);
    send(int'(LANE_A), 30, 0);  idle();
    send(int'(LANE_B), 33, 0);  idle();
    send(int'(LANE_XL), 31, 0); idle();
    send(int'(LANE_M), 32, 0);  idle();
    step();
    out_ready = 1'b1;
    drain();

    // Back-pressure
    do_reset();
    counting  = 1'b1;
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      expect_out(MW'(20 + k), 0, 0);
      send(int'(LANE_A), MW'(20 + k), 0);
    end
    check("bp_stall_on", PW'(lane_stall), PW'(1));
    check("bp_slot_maj", PW'(out_maj), PW'(20));
    expect_out(25, 0, 0);
    set_lane(int'(LANE_A), 25, 0);
    step(); step(); step();
    check("bp_stall_held", PW'(lane_stall), PW'(1));
    out_ready = 1'b1;
    send(int'(LANE_A), 25, 0);
    idle();
    check("bp_stall_off", PW'(lane_stall), '0);
    drain();
    counting = 1'b0;
    check("bp_stall_cycles", PW'(stall_cycles), PW'(4));
`ifdef DECODE_ARB_PERF_COUNTERS_EN
    check("perf_emitted", PW'(perf_emitted), PW'(6));
    check("perf_stall", PW'(perf_stall), PW'(stall_cycles));
`endif

    // Reset mid-stream with three entries buffered behind the slot
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) send(int'(LANE_A), MW'(40 + k), 0);
    idle();
    check("pre_rst_valid", PW'(out_valid), PW'(1));
    #1 rst = 1'b1;
    #1;
    check("mid_rst_valid", PW'(out_valid), '0);
    check("mid_rst_stall", PW'(lane_stall), '0);
    check("mid_rst_maj", PW'(out_maj), '0);
    @(posedge clk);
    #2 rst = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) step();
    check("post_rst_valid", PW'(out_valid), '0);
    check("final_sb_empty", PW'(sb.size()), '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/decode_result_arbiter.md
# decode_result_arbiter

Merges the results of the format-specific decoders (A, B, D, DS, X, XO, M, XL lanes) into one in-order decoded-instruction stream for the backend. Each lane's `enable_o` result is buffered in a small per-lane FIFO. The oldest buffered instruction by {major ID, minor ID} is selected into a registered output slot under a valid/ready handshake. Per-lane back-pressure drives each decoder's `stall_i`.

## Interface
- `NumLanes`, 8: number of format-decoder lanes.
- `LaneDepth`, 4: entries per lane FIFO (power of two, ≥2).
- `PayloadWidth`, 160: packed decoder result (opcode, address, func unit, is64Bit, PID, TID, rw/isReg flags, body), treated as opaque.
- `instructionCounterWidth`, 64: major ID width.
- `instMinIdWidth`, 7: minor ID width.

Ports:
- `clock_i`  in  1  single clock, rising edge.
- `reset_i`  in  1  asynchronous, active-high reset.
- `lane_valid_i`  in  NumLanes  per-lane result valid (decoder `enable_o`).
- `lane_payload_i`  in  NumLanes*PayloadWidth  lane i at slice i.
- `lane_majId_i`  in  NumLanes*instructionCounterWidth  major IDs.
- `lane_minId_i`  in  NumLanes*instMinIdWidth  minor IDs.
- `lane_stall_o`  out  NumLanes  per-lane back-pressure, drives decoder `stall_i`.
- `out_valid_o`  out  1  output slot holds an instruction.
- `out_ready_i`  in  1  backend accepts the slot this cycle.
- `out_payload_o`  out  PayloadWidth  selected payload.
- `out_majId_o`, `out_minId_o`  out  ID widths  selected IDs.
- `out_lane_o`  out  clog2(NumLanes)  source lane index.
- `perf_emitted_o`  out  32  instructions emitted. Present only with the macro.
- `perf_stall_o`  out  32  lane-stall cycles. Present only with the macro.

## Operation
- Lane handshake: an entry is captured when `lane_valid_i[i]=1` and `lane_stall_o[i]=0`. While stalled, the decoder holds its valid and payload unchanged.
- `lane_stall_o[i] = (count[i]==LaneDepth)`. It depends on registered state only, with no combinational path from `out_ready_i`.
- Selection: among non-empty lane FIFO heads, choose the smallest {majId, minId}, compared as an unsigned concatenation. On an exact tie, the lowest lane index wins. Major-ID wrap-around is not supported.
- Output slot loads when it is empty, or when `out_valid_o & out_ready_i`, and at least one head exists. The loaded head is popped in the same cycle.
- If the slot is drained and no head exists, `out_valid_o` falls to 0. Payload and ID outputs then hold their last value.
- Push and pop on the same lane in the same cycle: count is unchanged. Push on a full lane is impossible because the lane is stalled.
- A lane at count==LaneDepth that is popped drops `lane_stall_o[i]` on the following cycle.
- Reset, at any time including mid-transfer: all FIFO counts and pointers 0, `lane_stall_o`=0, `out_valid_o`=0, `out_payload_o`/IDs/`out_lane_o`=0, perf counters 0. Buffered entries are discarded.

## Timing
- Lane capture at edge t. The entry is selectable in cycle t+1 and appears on `out_valid_o` after edge t+1, giving 2-cycle latency.
- Sustained throughput: 1 instruction per cycle while `out_ready_i`=1.
- With `out_ready_i`=0, the slot holds. A lane stalls LaneDepth captures later.
- The output slot and all outputs are registered.

## Configuration
- `DECODE_ARB_PERF_COUNTERS_EN` defined:
  - `perf_emitted_o` increments on every `out_valid_o & out_ready_i`.
  - `perf_stall_o` increments once per cycle in which any bit of `lane_stall_o` is 1.
  - Both are 32-bit and wrap modulo 2^32.
- Undefined: both ports and counters are absent. All other behaviour is identical.

## Structure
- Shared package `decode_pkg`:
  - ID and payload width constants.
  - Lane index constants (LANE_A=0, LANE_B, LANE_D, LANE_DS, LANE_X, LANE_XO, LANE_M, LANE_XL).
  - An `is_older(maj,min,maj,min)` function.
- Sub-module `decode_lane_fifo`: one per lane. Circular buffer with push, pop, head, count and full.
- Top level contains the oldest-select tree, the output slot and the optional counters.

## Test plan
- Single instruction: reset, then lane 0 (A) valid for one cycle with majId=5, minId=0. Required: `out_valid_o`=1 two edges later, majId 5, `out_lane_o`=0, all stalls 0.
- Ordering across lanes: lane 4 receives majId 10, 12 and lane 0 receives majId 11, 13 on alternating cycles, with `out_ready_i`=1. Required output order 10, 11, 12, 13.
- Micro-op tie: majId 7 with minId 1 on lane 5 and minId 0 on lane 2, both buffered. Required: minId 0 is emitted first, then minId 1.
- Back-pressure: `out_ready_i`=0, lane 0 valid every cycle with majId 20, 21, and so on. Required:
  - `lane_stall_o[0]`=1 once 4 entries are buffered beyond the slot.
  - The held majId 25 is not captured until stall drops.
  - After release, output is 20..25 with no loss or duplication.
- Reset mid-stream: assert `reset_i` between edges while 3 entries are buffered. Required: `out_valid_o` and `lane_stall_o` go 0 immediately and nothing buffered is emitted after release.
- With `DECODE_ARB_PERF_COUNTERS_EN`: run the back-pressure scenario. Required: `perf_emitted_o`=6 and `perf_stall_o` equals the number of stalled cycles.
